led_share_arb: RTL and testbench

//  Round-robin arbiter sharing the 4-bit LED bank among NREQ pattern sources
//  (e.g. per-clock-domain blinkers resynchronised into the board clock domain).

---
 rtl/led_share_arb_pkg.sv | 16 +
 rtl/led_share_arb_rr_pick.sv | 29 ++
 rtl/led_share_arb.sv | 139 +++++++++++++
 tb/tb_led_share_arb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_share_arb_pkg.sv
// Shared state encoding, default widths and index helpers for the LED-bank arbiter.
package led_share_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int LED_W_DEF = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_share_arb_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping,
// with 'last' itself considered only when nobody else is asking.
module rr_pick
  import led_share_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_valid
);

  logic [IDX_W-1:0] cand_s;

  // Scan from the farthest candidate to the nearest so the nearest requester overwrites the rest.
  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    cand_s    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand_s    = IDX_W'((int'(last) + k) % NREQ);
      win_idx   = req[cand_s] ? cand_s : win_idx;
      win_valid = win_valid | req[cand_s];
    end
  end

endmodule

// File: rtl/led_share_arb.sv
// Round-robin owner of the LED bank: grant, follow the owner's pattern for a
// hold window, blank for a gap, then re-arbitrate.
module led_share_arb
  import led_share_arb_pkg::*;
#(
  parameter int              NREQ     = 4,
  parameter int              LED_W    = LED_W_DEF,
  parameter int              CNT_W    = 27,
  parameter logic [CNT_W-1:0] HOLD_MAX = 27'd49_999_999,
  parameter logic [CNT_W-1:0] GAP_MAX  = 27'd4_999_999
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LED_W-1:0] pat,
  output logic [LED_W-1:0]      led,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy
);

  localparam int               IDX_W    = idx_width(NREQ);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);
  localparam logic [NREQ-1:0]  GNT_ONE  = {{(NREQ-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             busy_q, busy_d;

  logic [LED_W-1:0] pat_arr [NREQ];
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req       (req),
    .last      (last_q),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  // Unpack the flat pattern bus into one slot per source.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      pat_arr[i] = pat[i*LED_W +: LED_W];
    end
  end

  // Next-state and next-output logic; last_q doubles as the current owner while in HOLD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    led_d   = led_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          last_d  = win_idx;
          led_d   = pat_arr[win_idx];
          gnt_d   = GNT_ONE << win_idx;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          led_d   = '0;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      ST_HOLD: begin
        // A dropped request ends the window even on its final cycle.
        if (!req[last_q] || (cnt_q == HOLD_MAX)) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          led_d   = '0;
          gnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_HOLD;
          cnt_d   = cnt_q + CNT_ONE;
          led_d   = pat_arr[last_q];
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_MAX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          led_d   = '0;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_GAP;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        last_d  = LAST_RST;
        led_d   = '0;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= LAST_RST;
      led_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      led_q   <= led_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign led  = led_q;
  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_led_share_arb.sv
// Self-checking bench for led_share_arb: directed scenarios plus randomized
// traffic, all compared against a cycle-level behavioural model.
module tb_led_share_arb;

  localparam int               NREQ     = 4;
  localparam int               LED_W    = 4;
  localparam int               CNT_W    = 27;
  localparam logic [CNT_W-1:0] HOLD_MAX = 27'd7;
  localparam logic [CNT_W-1:0] GAP_MAX  = 27'd1;
  localparam int               HOLD_CYC = 8;
  localparam int               GAP_CYC  = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*LED_W-1:0] pat = '0;
  logic [LED_W-1:0]      led;
  logic [NREQ-1:0]       gnt;
  logic                  busy;

  int checks = 0;
  int passed = 0;
  logic mon_en = 1'b0;

  // Behavioural model: mode 0 idle, 1 holding, 2 blank gap; m_left counts cycles still to go.
  int              m_mode = 0;
  int              m_left = 0;
  int              m_last = NREQ - 1;
  int              m_w;
  logic [LED_W-1:0] m_led  = '0;
  logic [NREQ-1:0]  m_gnt  = '0;
  logic             m_busy = 1'b0;

  led_share_arb #(
    .NREQ     (NREQ),
    .LED_W    (LED_W),
    .CNT_W    (CNT_W),
    .HOLD_MAX (HOLD_MAX),
    .GAP_MAX  (GAP_MAX)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .pat  (pat),
    .led  (led),
    .gnt  (gnt),
    .busy (busy)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  always_comb m_w = pick(req, m_last);

  always @(posedge clk) begin
    if (!rst) begin
      m_mode <= 0; m_left <= 0; m_last <= NREQ - 1;
      m_led <= '0; m_gnt <= '0; m_busy <= 1'b0;
    end else if (m_mode == 0) begin
      if (m_w >= 0) begin
        m_mode <= 1; m_left <= HOLD_CYC - 1; m_last <= m_w;
        m_gnt <= 4'(1 << m_w); m_led <= pat[m_w*LED_W +: LED_W]; m_busy <= 1'b1;
      end
    end else if (m_mode == 1) begin
      if (!req[m_last] || m_left == 0) begin
        m_mode <= 2; m_left <= GAP_CYC - 1; m_gnt <= '0; m_led <= '0;
      end else begin
        m_left <= m_left - 1; m_led <= pat[m_last*LED_W +: LED_W];
      end
    end else begin
      if (m_left == 0) begin
        m_mode <= 0; m_busy <= 1'b0;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  // Lockstep comparison of every output against the model, mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ({led, gnt, busy} !== {m_led, m_gnt, m_busy})
        $display("FAIL model_lockstep t=%0t led/gnt/busy got %h/%b/%b expected %h/%b/%b",
                 $time, led, gnt, busy, m_led, m_gnt, m_busy);
      else passed++;
    end
  end

  task automatic test_reset();
    rst = 1'b0; req = 4'hF; pat = 16'h4321;
    @(posedge clk);
    mon_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({led, gnt, busy} !== 9'd0)
        $display("FAIL reset_outputs got led=%h gnt=%b busy=%b expected all zero", led, gnt, busy);
      else passed++;
    end
  endtask

  task automatic test_single();
    int n, z;
    bit run;
    rst = 1'b1; req = 4'b0010; pat = 16'h35A6;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010 || led !== 4'hA)
      $display("FAIL single_latency got gnt=%b led=%h expected 0010/a", gnt, led);
    else passed++;
    n = 1; run = 1'b1;
    while (run && n < 20) begin
      @(negedge clk);
      if (gnt === 4'b0010 && led === 4'hA) n++;
      else run = 1'b0;
    end
    checks++;
    if (n != HOLD_CYC) $display("FAIL single_hold_len got %0d expected %0d", n, HOLD_CYC);
    else passed++;
    z = 0;
    while (gnt === 4'b0000 && led === 4'h0 && z < 20) begin
      z++;
      @(negedge clk);
    end
    checks++;
    if (z != GAP_CYC + 1) $display("FAIL single_gap_len got %0d expected %0d", z, GAP_CYC + 1);
    else passed++;
    checks++;
    if (gnt !== 4'b0010) $display("FAIL single_regrant got %b expected 0010", gnt);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] seq [5];
    logic [NREQ-1:0] exp_seq [5];
    logic [NREQ-1:0] prev;
    int g, c;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    for (int i = 0; i < 5; i++) seq[i] = '0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1; req = 4'hF; pat = 16'h4321;
    prev = '0; g = 0; c = 0;
    while (g < 5 && c < 200) begin
      @(negedge clk);
      c++;
      if (gnt !== 4'b0000 && prev === 4'b0000) begin
        seq[g] = gnt;
        g++;
      end
      if (gnt !== 4'b0000) begin
        checks++;
        if (led !== 4'($clog2(gnt) + 1))
          $display("FAIL rr_led gnt=%b got led=%h expected %h", gnt, led, 4'($clog2(gnt) + 1));
        else passed++;
      end
      prev = gnt;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (seq[i] !== exp_seq[i])
        $display("FAIL rr_order grant %0d got %b expected %b", i, seq[i], exp_seq[i]);
      else passed++;
    end
  endtask

  task automatic test_early_release();
    int n;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1; req = 4'b0100; pat = 16'($urandom);
    n = 0;
    while (gnt !== 4'b0100 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (gnt !== 4'b0100 || n != 1) $display("FAIL early_grant got gnt=%b after %0d cycles expected 0100 after 1", gnt, n);
    else passed++;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0100) $display("FAIL early_hold got %b expected 0100", gnt);
      else passed++;
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if ({led, gnt, busy} !== {4'h0, 4'b0000, 1'b1})
      $display("FAIL early_gap_start got led=%h gnt=%b busy=%b expected 0/0000/1", led, gnt, busy);
    else passed++;
    @(negedge clk);
    checks++;
    if ({gnt, busy} !== {4'b0000, 1'b1}) $display("FAIL early_gap2 got gnt=%b busy=%b expected 0000/1", gnt, busy);
    else passed++;
    @(negedge clk);
    checks++;
    if ({gnt, busy} !== {4'b0000, 1'b0}) $display("FAIL early_idle got gnt=%b busy=%b expected 0000/0", gnt, busy);
    else passed++;
  endtask

  task automatic test_reset_mid_hold();
    int n;
    req = 4'b0100;
    n = 0;
    while (gnt !== 4'b0100 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (gnt !== 4'b0100) $display("FAIL midhold_grant got %b expected 0100", gnt);
    else passed++;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({led, gnt, busy} !== 9'd0)
      $display("FAIL midhold_reset got led=%h gnt=%b busy=%b expected all zero", led, gnt, busy);
    else passed++;
    rst = 1'b1; req = 4'hF;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) $display("FAIL midhold_first_src0 got %b expected 0001", gnt);
    else passed++;
  endtask

  task automatic test_live_pattern();
    int n;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1; req = 4'b1000;
    pat = {4'h5, 12'($urandom)};
    n = 0;
    while (gnt !== 4'b1000 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (gnt !== 4'b1000 || led !== 4'h5) $display("FAIL live_initial got gnt=%b led=%h expected 1000/5", gnt, led);
    else passed++;
    pat[15:12] = 4'hC;
    @(negedge clk);
    checks++;
    if (led !== 4'hC) $display("FAIL live_follow got %h expected c", led);
    else passed++;
    pat[3:0] = ~pat[3:0];
    pat[7:4] = pat[7:4] + 4'h1;
    @(negedge clk);
    checks++;
    if (led !== 4'hC) $display("FAIL live_nonowner got %h expected c", led);
    else passed++;
  endtask

  task automatic test_random();
    int grants;
    logic [NREQ-1:0] prev;
    grants = 0; prev = gnt;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (gnt !== 4'b0000 && prev === 4'b0000) grants++;
      prev = gnt;
      if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
      pat = 16'($urandom);
      rst = ($urandom_range(0, 79) != 0);
    end
    rst = 1'b1;
    checks++;
    if (grants < 5) $display("FAIL random_grants got %0d grants expected at least 5", grants);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_reset_mid_hold();
    test_live_pattern();
    test_random();
    @(negedge clk);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
